// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS IF stage: FSM state codes, PC step and the
// NOP word used to blank the IF/ID payload.
package mips_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Payload handed to the IF/ID register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
  } if_slot_t;

  // Sequential PC; wraps mod 2^32 with no alignment check.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, the hazard/branch logic,
// instruction memory and the IF/ID register.
interface fetch_sequencer_if;

  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [31:0] if_instr;
  logic        flush_ifid;
  logic        fetch_err;

  // master: the fetch sequencer itself
  modport master (
    input  stall, pcsrc, branch_target, imem_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_npc, if_instr,
           flush_ifid, fetch_err
  );

  // slave: the surrounding pipeline and instruction memory
  modport slave (
    output stall, pcsrc, branch_target, imem_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_npc, if_instr,
           flush_ifid, fetch_err
  );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts consecutive cycles an imem request waits for ready and raises a
// sticky fetch_err once the wait reaches MAX_WAIT cycles.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic restart,
  output logic fetch_err
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else if (restart || !waiting) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 8'd1;
      // This waiting cycle brings the count to LIMIT; the request stays up.
      if (wait_cnt >= LIMIT - 8'd1) fetch_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: PC register, imem request FSM, branch redirects, stalls
// and IF/ID flush. Optional perf counters are enabled by FETCH_PERF_EN.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_bubble
`endif
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  if_slot_t    slot;
  logic        if_valid;
  logic        flush_ifid;

  logic        req;
  logic        xfer;
  logic        waiting;
  logic        drain_enter;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req = 1'b0;
    case (state)
      S_REQ:   req = !(if_valid && bus.stall);
      S_DRAIN: req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  assign xfer        = req & bus.imem_ready;
  assign waiting     = req & ~bus.imem_ready;
  // A redirect while the address is on the bus unacknowledged must not move it.
  assign drain_enter = (state == S_REQ) & bus.pcsrc & waiting;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.if_valid   = if_valid;
  assign bus.if_pc      = slot.pc;
  assign bus.if_npc     = slot.npc;
  assign bus.if_instr   = slot.instr;
  assign bus.flush_ifid = flush_ifid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      pend_tgt   <= '0;
      if_valid   <= 1'b0;
      slot       <= '{pc: 32'h0, npc: 32'h0, instr: INSTR_NOP};
      flush_ifid <= 1'b0;
    end else begin
      flush_ifid <= bus.pcsrc;
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (bus.pcsrc) pc <= bus.branch_target;
        end
        S_REQ: begin
          if (bus.pcsrc) begin
            if_valid <= 1'b0;
            if (waiting) begin
              pend_tgt <= bus.branch_target;
              state    <= S_DRAIN;
            end else begin
              pc <= bus.branch_target;
            end
          end else if (xfer) begin
            slot     <= '{pc: pc, npc: pc_next(pc), instr: bus.imem_rdata};
            if_valid <= 1'b1;
            pc       <= pc_next(pc);
          end else if (if_valid && !bus.stall) begin
            if_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if_valid <= 1'b0;
          if (bus.pcsrc) pend_tgt <= bus.branch_target;
          // Response to the abandoned address is dropped; the latest redirect wins.
          if (xfer) begin
            pc    <= bus.pcsrc ? bus.branch_target : pend_tgt;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .restart   (drain_enter),
    .fetch_err (bus.fetch_err)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch  <= '0;
      perf_bubble <= '0;
    end else begin
      if (state == S_REQ && xfer && !bus.pcsrc && perf_fetch != '1)
        perf_fetch <= perf_fetch + 32'd1;
      if (state != S_IDLE && !if_valid && perf_bubble != '1)
        perf_bubble <= perf_bubble + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
